// File: rtl/med_pkg.sv
// med_pkg: shared types and helpers for the med_auto median/max filter.
// Holds the FSM state enum, compute-length function and N/WIDTH legality check.
package med_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DONE
  } state_t;

  // Compute cycles for one window: K*(N+1) for median, N-1 for max.
  function automatic int clen(input int n, input logic mode);
    int k;
    k = (n - 1) / 2;
    return mode ? (n - 1) : (k * (n + 1));
  endfunction

  function automatic bit legal(input int n, input int w);
    return (n >= 3) && (n <= 15) && (n % 2 == 1)
        && (w >= 2) && (w <= 16);
  endfunction

endpackage

// File: rtl/med_auto_mce.sv
// med_mce: combinational compare-exchange of two unsigned operands.
// Ports: a, b in; hi = max(a,b), lo = min(a,b) out.
module med_mce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic ge;

  assign ge = (a >= b);
  assign hi = ge ? a : b;
  assign lo = ge ? b : a;

endmodule

// File: rtl/med_auto.sv
// med_auto: N-sample windowed median/max filter, one compare-exchange unit.
// Ports: CLK, RST (sync, high), DI/DSI/MODE in; READY, DO, DSO out.
module med_auto #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  input  logic             MODE,
  output logic             READY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
);

  import med_pkg::*;

  if (!legal(N, WIDTH)) begin : g_bad
    $error("med_auto: illegal N or WIDTH");
  end

  localparam int K    = (N - 1) / 2;
  localparam int CMED = clen(N, 1'b0);
  localparam int CMAX = clen(N, 1'b1);
  localparam int SCW  = $clog2(N + 1);
  localparam int CW   = $clog2(CMED + 1);
  localparam int SW   = $clog2(N);
  localparam int JW   = $clog2(K + 1);

  state_t           st, nx;
  logic [SCW-1:0]   scnt;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    sub;
  logic [JW-1:0]    pj;
  logic             byp;
  logic             mode_r;
  logic             cap;
  logic             last_s;
  logic             last_c;
  logic             seg_end;
  logic [WIDTH-1:0] r [N];
  logic [WIDTH-1:0] hi, lo;

  med_mce #(.WIDTH(WIDTH)) u_mce (
    .a (r[0]),
    .b (r[N-1]),
    .hi(hi),
    .lo(lo)
  );

  assign cap    = DSI && READY && !RST;
  assign last_s = (scnt == SCW'(N - 1));
  assign last_c = (cnt == (mode_r ? CW'(CMAX - 1)
                                  : CW'(CMED - 1)));

  // Pass pj: (N-1-pj) compare cycles, then (pj+1) bypass cycles.
  assign seg_end = byp ? (int'(sub) == int'(pj))
                       : (int'(sub) == N - 2 - int'(pj));

  always_ff @(posedge CLK) begin
    if (RST) st <= IDLE;
    else     st <= nx;
  end

  always_comb begin
    nx    = st;
    READY = 1'b0;
    unique case (st)
      IDLE: begin
        READY = 1'b1;
        if (DSI) nx = LOAD;
      end
      LOAD: begin
        READY = 1'b1;
        if (DSI && last_s) nx = SORT;
      end
      SORT: if (last_c) nx = DONE;
      DONE: nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scnt   <= '0;
      cnt    <= '0;
      sub    <= '0;
      pj     <= '0;
      byp    <= 1'b0;
      mode_r <= 1'b0;
    end else begin
      if (st == IDLE && DSI) begin
        scnt   <= SCW'(1);
        mode_r <= MODE;
      end else if (st == LOAD && DSI) begin
        scnt <= last_s ? '0 : scnt + SCW'(1);
      end
      if (st == SORT) begin
        cnt <= cnt + CW'(1);
        if (seg_end) begin
          sub <= '0;
          byp <= !byp;
          if (byp) pj <= pj + JW'(1);
        end else begin
          sub <= sub + SW'(1);
        end
      end else begin
        cnt <= '0;
        sub <= '0;
        pj  <= '0;
        byp <= 1'b0;
      end
    end
  end

  // r[0] accumulates the running max; compare pushes the loser into
  // r[1], bypass rotates the whole chain to park found maxima.
  always_ff @(posedge CLK) begin
    if (cap) begin
      r[0] <= DI;
      for (int i = 1; i < N; i++) r[i] <= r[i-1];
    end else if (st == SORT) begin
      r[0] <= byp ? r[N-1] : hi;
      r[1] <= byp ? r[0] : lo;
      for (int i = 2; i < N; i++) r[i] <= r[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DO  <= '0;
      DSO <= 1'b0;
    end else begin
      DSO <= (st == DONE);
      if (st == DONE) DO <= r[0];
    end
  end

endmodule

// File: doc/med_auto.md
MED_AUTO -- requirements
Module: med_auto

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits; SHALL be legal for 2..16.
REQ-002 Parameter N, default 9, window size in samples; SHALL be odd and in 3..15, with elaboration-time error otherwise.
REQ-003 Port CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port RST  input  1  reset; synchronous, active-high.
REQ-005 Port DI  input  WIDTH  sample data, unsigned.
REQ-006 Port DSI  input  1  sample strobe; DI SHALL be captured on an edge where DSI=1 and READY=1.
REQ-007 Port MODE  input  1  result select, 0=median, 1=maximum; sampled on the edge that captures the first sample of a window.
REQ-008 Port READY  output  1  high when the block accepts samples.
REQ-009 Port DO  output  WIDTH  result; holds the last result until the next DSO.
REQ-010 Port DSO  output  1  one-cycle pulse marking DO valid.

Function
REQ-011 The FSM SHALL have four states: IDLE, LOAD, SORT and DONE.
REQ-012 FSM transitions: IDLE->LOAD on the first accepted sample; LOAD->SORT on the edge capturing sample N; SORT->DONE after the compute count; DONE->IDLE after exactly one cycle.
REQ-013 READY SHALL be 1 in IDLE and LOAD, and 0 in SORT and DONE.
REQ-014 In LOAD, a DSI=0 cycle SHALL hold the sample count and register contents; loading resumes on the next DSI=1 with no limit on gap length.
REQ-015 DSI=1 while READY=0 SHALL be ignored: no capture, no state change, no error.
REQ-016 Compute length SHALL be K*(N+1) cycles with K=(N-1)/2 in median mode (40 for N=9), and N-1 cycles in max mode (8 for N=9).
REQ-017 Median result SHALL be the (K+1)-th largest of the N captured samples; max result SHALL be the largest.
REQ-018 Duplicate values SHALL be handled: equal samples count separately toward rank.
REQ-019 DO SHALL update and DSO SHALL pulse in DONE, i.e. one cycle after the last compute cycle.
REQ-020 DO SHALL be stable outside DSO cycles.
REQ-021 Internal bypass sequencing for median mode: for j=0..K-1, (N-1-j) cycles compare, then (j+1) cycles bypass; followed by K compare cycles.
REQ-022 In max mode the first N-1 compare cycles SHALL be used only, then terminate.
REQ-023 The sample counter SHALL be ceil(log2(N+1)) bits, the compute counter sized for K*(N+1), and neither SHALL wrap within a window.
REQ-024 A new window SHALL be accepted on the edge after DONE, giving back-to-back throughput of N+C+1 cycles, with C the compute length of REQ-016.

Reset
REQ-025 RST=1 at a rising edge SHALL force IDLE, clear both counters, and set DO=0, DSO=0 and READY=1 on the following cycle.
REQ-026 Reset mid-LOAD or mid-SORT SHALL discard the partial window and produce no DSO.
REQ-027 Sample registers need not be cleared by reset, but no stale value SHALL ever reach DO.
REQ-028 RST held high SHALL override DSI.

Structure
REQ-029 Package med_pkg SHALL hold the state enum, the compute-length function of (N, MODE), and the N/WIDTH legality check.
REQ-030 Datapath: a shift chain of N WIDTH-bit registers with one compare-exchange unit, in sub-module med_mce; med_mce is purely combinational, taking two operands and returning max and min.
REQ-031 The controller (FSM, counters, bypass generation) SHALL reside in med_auto.

Verification
REQ-032 Median: N=9, W=8, DI=7,3,9,1,5,8,2,6,4 contiguous, MODE=0 -> DSO 41 edges after the last sample, DO=5.
REQ-033 Max: same data with MODE=1 -> DSO 9 edges after the last sample, DO=9.
REQ-034 Gaps and duplicates: 9 samples of 255 with 3-cycle DSI gaps after samples 2 and 6 -> DO=255; DSI pulses during SORT ignored with READY=0.
REQ-035 Reset mid-SORT at cycle 20 -> no DSO, DO=0, READY=1; the next window still yields the correct median.
REQ-036 Alternate parameters: N=3, W=12, DI=4095,0,2048 -> DO=2048 after 4 compute cycles.
REQ-037 Random regression: 1000 random windows in back-to-back MODE=0 and MODE=1, checked against a reference sort.
